// File: rtl/day3_pkg.sv
// rtl/day3_pkg.sv - shared types and constants for the day3 bank scheduler
package day3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int PAIR_W  = 7;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // Two-digit joltage: first*10 + second, at most 99 so it fits PAIR_W.
    function automatic logic [PAIR_W-1:0] pair_value(
        input logic [DIGIT_W-1:0] first,
        input logic [DIGIT_W-1:0] second
    );
        return ({3'b000, first} * 7'd10) + {3'b000, second};
    endfunction

endpackage

// File: rtl/day3_pair_max.sv
// rtl/day3_pair_max.sv - running max two-digit pair over the digits of one bank
module day3_pair_max
    import day3_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               accept,
    input  logic [DIGIT_W-1:0] digit,
    output logic [PAIR_W-1:0]  best_pair,
    output logic [LEN_W-1:0]   len
);

    logic [DIGIT_W-1:0] best_first;
    logic [PAIR_W-1:0]  candidate;

    // Candidate uses best_first before this digit updates it, so a digit never pairs with itself.
    assign candidate = pair_value(best_first, digit);

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            best_first <= '0;
            best_pair  <= '0;
            len        <= '0;
        end else if (accept) begin
            if ((len != '0) && (candidate > best_pair)) begin
                best_pair <= candidate;
            end
            if (digit > best_first) begin
                best_first <= digit;
            end
            if (len != '1) begin
                len <= len + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/day3_bank_scheduler.sv
// rtl/day3_bank_scheduler.sv - frames digit stream into banks and sums per-bank joltage; optional DAY3_BANK_RESULT_EN
module day3_bank_scheduler
    import day3_pkg::*;
#(
    parameter int TOTAL_W    = 32,
    parameter int BANK_CNT_W = 16,
    parameter int LEN_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGIT_W-1:0]    in_digit,
    input  logic                  in_last,
    input  logic                  in_eof,
    output logic                  busy,
    output logic                  done,
    output logic [TOTAL_W-1:0]    total,
    output logic [BANK_CNT_W-1:0] bank_count,
    output logic                  error
`ifdef DAY3_BANK_RESULT_EN
    ,
    output logic                  bank_valid,
    output logic [PAIR_W-1:0]     bank_result
`endif
);

    state_t             state, state_nx;
    logic               eof_q;
    logic               accept;
    logic               digit_ok;
    logic               start_run;
    logic               clear_dp;
    logic               short_bank;
    logic [PAIR_W-1:0]  best_pair;
    logic [LEN_W-1:0]   len;
    logic [PAIR_W-1:0]  contrib;

    assign in_ready   = (state == RUN);
    assign busy       = (state == RUN) || (state == FLUSH);
    assign done       = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign digit_ok   = (in_digit <= DIGIT_MAX);
    assign short_bank = (len < LEN_W'(2));
    assign contrib    = short_bank ? '0 : best_pair;

`ifdef DAY3_BANK_RESULT_EN
    assign bank_valid  = (state == FLUSH);
    assign bank_result = best_pair;
`endif

    always_comb begin
        state_nx  = state;
        start_run = 1'b0;
        clear_dp  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = RUN;
                    start_run = 1'b1;
                    clear_dp  = 1'b1;
                end
            end
            RUN: begin
                if (accept && in_last) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                state_nx = eof_q ? DONE : RUN;
                clear_dp = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    day3_pair_max #(
        .LEN_W(LEN_W)
    ) u_pair_max (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (clear_dp),
        .accept   (accept && digit_ok),
        .digit    (in_digit),
        .best_pair(best_pair),
        .len      (len)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            eof_q      <= 1'b0;
            total      <= '0;
            bank_count <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_run) begin
                eof_q      <= 1'b0;
                total      <= '0;
                bank_count <= '0;
                error      <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    eof_q <= in_eof;
                end
                // Bad digits and eof without last are consumed but flagged.
                if (!digit_ok || (in_eof && !in_last)) begin
                    error <= 1'b1;
                end
            end
            if (state == FLUSH) begin
                total      <= total + {{(TOTAL_W-PAIR_W){1'b0}}, contrib};
                bank_count <= bank_count + BANK_CNT_W'(1);
                if (short_bank) begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_day3_bank_scheduler.sv
// tb/tb_day3_bank_scheduler.sv - directed table-driven bench for day3_bank_scheduler
module tb_day3_bank_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        in_eof;
    logic        busy;
    logic        done;
    logic [31:0] total;
    logic [15:0] bank_count;
    logic        error;
`ifdef DAY3_BANK_RESULT_EN
    logic        bank_valid;
    logic [6:0]  bank_result;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit    do_start;
        string digits;
        bit    eof;
        bit    gaps;
        int    exp_bank;
        int    exp_total;
        int    exp_count;
        bit    exp_err;
        bit    exp_done;
    } vec_t;

    vec_t vecs[11];

    always #5 clock = ~clock;

    day3_bank_scheduler #(
        .TOTAL_W(32),
        .BANK_CNT_W(16),
        .LEN_W(8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .in_eof    (in_eof),
        .busy      (busy),
        .done      (done),
        .total     (total),
        .bank_count(bank_count),
        .error     (error)
`ifdef DAY3_BANK_RESULT_EN
        ,
        .bank_valid (bank_valid),
        .bank_result(bank_result)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] char2dig(input byte c);
        if (c >= 8'h41) return 4'(c - 8'h41 + 8'd10);
        return 4'(c - 8'h30);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Streams one bank; returns at the negedge one cycle after the close (results visible).
    task automatic send_bank(input vec_t v);
        int n;
        int budget;
        n = v.digits.len();
        for (int i = 0; i < n; i++) begin
            if (v.gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clock);
                end
            end
            in_valid = 1'b1;
            in_digit = char2dig(v.digits.getc(i));
            in_last  = (i == n - 1);
            in_eof   = (i == n - 1) && v.eof;
            budget = 0;
            while (!in_ready && budget < 50) begin
                @(negedge clock);
                budget++;
            end
            if (!in_ready) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        check("flush_ready_low", in_ready, 0);
        check("flush_busy", busy, 1);
`ifdef DAY3_BANK_RESULT_EN
        check("bank_valid", bank_valid, 1);
        check("bank_result", bank_result, v.exp_bank);
`endif
        // Hostile beat held during the bubble must not be taken.
        in_valid = 1'b1;
        in_digit = 4'd9;
        in_last  = 1'b1;
        in_eof   = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        if (v.do_start) pulse_start();
        send_bank(v);
        check("total", total, v.exp_total);
        check("bank_count", bank_count, v.exp_count);
        check("error", error, v.exp_err);
        check("done", done, v.exp_done);
        if (!v.eof) check("ready_after_bubble", in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = '{1, "987654321111111", 0, 0, 98, 98, 1, 0, 0};
        vecs[1]  = '{0, "811111111111119", 0, 0, 89, 187, 2, 0, 0};
        vecs[2]  = '{0, "234234234234278", 0, 0, 78, 265, 3, 0, 0};
        vecs[3]  = '{0, "818181911112111", 1, 0, 92, 357, 4, 0, 1};
        vecs[4]  = '{1, "987654321111111", 0, 1, 98, 98, 1, 0, 0};
        vecs[5]  = '{0, "811111111111119", 0, 1, 89, 187, 2, 0, 0};
        vecs[6]  = '{0, "234234234234278", 0, 1, 78, 265, 3, 0, 0};
        vecs[7]  = '{0, "818181911112111", 1, 1, 92, 357, 4, 0, 1};
        vecs[8]  = '{1, "5",               1, 0, 0,  0,   1, 1, 1};
        vecs[9]  = '{1, "3B7",             1, 0, 37, 37,  1, 1, 1};
        vecs[10] = '{1, "19",              1, 0, 19, 19,  1, 0, 1};

        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_digit = 4'd0;
        in_last  = 1'b0;
        in_eof   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 0);
        check("rst_total", total, 0);
        check("rst_count", bank_count, 0);
        check("rst_error", error, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_ready", in_ready, 0);

        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i]);
        end

        // Reset in the middle of the third bank.
        apply_vec(vecs[0]);
        apply_vec(vecs[1]);
        in_valid = 1'b1;
        in_digit = 4'd2;
        @(negedge clock);
        in_digit = 4'd3;
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clock);
        reset_n  = 1'b1;
        check("mid_rst_total", total, 0);
        check("mid_rst_count", bank_count, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        @(negedge clock);
        check("mid_rst_idle", busy, 0);
        for (int i = 0; i < 4; i++) begin
            apply_vec(vecs[i]);
        end

        // start during RUN must not clear the accumulator.
        apply_vec(vecs[0]);
        pulse_start();
        check("start_in_run_busy", busy, 1);
        check("start_in_run_total", total, 98);
        v = '{0, "19", 1, 0, 19, 117, 2, 0, 1};
        apply_vec(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
